audio_pwm_out: RTL and testbench

- Downstream consumer of the 32-entry sound FIFO, which packs two 8-bit signed samples per 16-bit word: low byte is played first, high byte second.
- Paces playback with a sample-rate divider and plays the two bytes on consecutive sample ticks.
- Pulses the FIFO's next-sample request once per word and drives a 1-bit PWM audio pin through an 8-bit PWM generator.
- Sits between the FIFO head output and the board's RC-filtered audio pin.

---
 rtl/audio_pwm_out_if.sv | 9 +
 rtl/audio_pwm_out.sv | 120 ++++++++++++
 tb/tb_audio_pwm_out.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pwm_out_if.sv
// FIFO-head bus between the sound FIFO (master) and audio_pwm_out (slave).
// The slave advances the FIFO by pulsing OwNextAudioSamples once per 16-bit word.
interface audio_pwm_out_if;
    logic [15:0] IbAudioSamples;
    logic        OwNextAudioSamples;

    modport master (output IbAudioSamples, input OwNextAudioSamples);
    modport slave  (input IbAudioSamples, output OwNextAudioSamples);
endinterface

// File: rtl/audio_pwm_out.sv
// Plays packed 8-bit signed sample pairs from the sound FIFO as 8-bit PWM audio.
// Optional attenuation input IbVolume is compiled in when AUDIO_VOLUME_EN is defined.
module audio_pwm_out #(
    parameter int DIVIDER = 3052
) (
    input  logic              IwClk,
    input  logic              IwRst_n,
    input  logic              IwEnable,
`ifdef AUDIO_VOLUME_EN
    input  logic [1:0]        IbVolume,
`endif
    audio_pwm_out_if.slave    fifo,
    output logic signed [7:0] ObSample,
    output logic              OwSampleStrobe,
    output logic              OwPwm
);

    localparam logic [15:0] DIV_LAST = 16'(DIVIDER - 1);

    typedef enum logic [1:0] {IDLE, PLAY_LO, PLAY_HI} state_t;

    state_t             r_state;
    logic [15:0]        r_div_cnt;
    logic [15:0]        r_hold;
    logic signed [7:0]  r_sample;
    logic               r_strobe;
    logic               r_next;
    logic [7:0]         r_pend_duty;
    logic [7:0]         r_act_duty;
    logic [7:0]         r_pwm_cnt;
    logic               r_pwm;

    logic               w_tick;
    logic [1:0]         w_shift;
    logic signed [7:0]  w_raw;
    logic signed [7:0]  w_play;

    function automatic logic signed [7:0] attenuate(input logic signed [7:0] s,
                                                    input logic [1:0] sh);
        return s >>> sh;
    endfunction

    // Two's complement to offset binary: flipping the sign bit maps -128..127 onto 0..255.
    function automatic logic [7:0] to_offset(input logic signed [7:0] s);
        return s ^ 8'h80;
    endfunction

`ifdef AUDIO_VOLUME_EN
    assign w_shift = IbVolume;
`else
    assign w_shift = 2'd0;
`endif

    assign w_tick = IwEnable && (r_div_cnt == 16'd0);
    assign w_raw  = (r_state == PLAY_HI) ? r_hold[15:8] : fifo.IbAudioSamples[7:0];
    assign w_play = attenuate(w_raw, w_shift);

    always_ff @(posedge IwClk or negedge IwRst_n) begin
        if (!IwRst_n) begin
            r_div_cnt <= 16'd0;
        end else if (!IwEnable || r_div_cnt == DIV_LAST) begin
            r_div_cnt <= 16'd0;
        end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
        end
    end

    // IDLE shares the PLAY_LO action: the first enabled cycle is always a tick.
    always_ff @(posedge IwClk or negedge IwRst_n) begin
        if (!IwRst_n) begin
            r_state     <= IDLE;
            r_hold      <= 16'd0;
            r_sample    <= 8'sd0;
            r_strobe    <= 1'b0;
            r_next      <= 1'b0;
            r_pend_duty <= 8'h80;
        end else begin
            r_strobe <= 1'b0;
            r_next   <= 1'b0;
            if (!IwEnable) begin
                r_state     <= IDLE;
                r_pend_duty <= 8'h80;
            end else if (w_tick) begin
                r_sample    <= w_play;
                r_strobe    <= 1'b1;
                r_pend_duty <= to_offset(w_play);
                case (r_state)
                    IDLE, PLAY_LO: begin
                        r_hold  <= fifo.IbAudioSamples;
                        r_next  <= 1'b1;
                        r_state <= PLAY_HI;
                    end
                    PLAY_HI: r_state <= PLAY_LO;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Duty is reloaded only at the period wrap so a period never changes width mid-way.
    always_ff @(posedge IwClk or negedge IwRst_n) begin
        if (!IwRst_n) begin
            r_pwm_cnt  <= 8'd0;
            r_act_duty <= 8'h80;
            r_pwm      <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_pwm     <= (r_pwm_cnt < r_act_duty);
            if (r_pwm_cnt == 8'hFF) begin
                r_act_duty <= r_pend_duty;
            end
        end
    end

    assign fifo.OwNextAudioSamples = r_next;
    assign ObSample                = r_sample;
    assign OwSampleStrobe          = r_strobe;
    assign OwPwm                   = r_pwm;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Randomized self-checking bench for audio_pwm_out against a tick-index reference model.
// Define AUDIO_VOLUME_EN for both bench and RTL to exercise the volume shifter.
module tb_audio_pwm_out;

    localparam int DIV = 300;

    logic              IwClk = 1'b0;
    logic              IwRst_n;
    logic              IwEnable;
    logic [1:0]        IbVolume;
    logic signed [7:0] ObSample;
    logic              OwSampleStrobe;
    logic              OwPwm;

    audio_pwm_out_if bus ();

    audio_pwm_out #(.DIVIDER(DIV)) dut (
        .IwClk          (IwClk),
        .IwRst_n        (IwRst_n),
        .IwEnable       (IwEnable),
`ifdef AUDIO_VOLUME_EN
        .IbVolume       (IbVolume),
`endif
        .fifo           (bus),
        .ObSample       (ObSample),
        .OwSampleStrobe (OwSampleStrobe),
        .OwPwm          (OwPwm)
    );

    always #5 IwClk = ~IwClk;

    int tests = 0;
    int fails = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sample k of an enabled run plays at enabled cycle k*DIV;
    // even k starts a new word (low byte), odd k plays its high byte.
    int          n, en_run, k, v, sc, m_vol;
    logic [15:0] m_word;
    logic [7:0]  m_sample, m_pending, m_active, byte_sel;
    logic        m_strobe, m_next, m_pwm;

    always @(posedge IwClk or negedge IwRst_n) begin
        if (!IwRst_n) begin
            n = 0; en_run = 0; m_word = 16'd0;
            m_sample = 8'd0; m_pending = 8'h80; m_active = 8'h80;
            m_strobe = 1'b0; m_next = 1'b0; m_pwm = 1'b0;
        end else begin
`ifdef AUDIO_VOLUME_EN
            m_vol = int'(IbVolume);
`else
            m_vol = 0;
`endif
            m_pwm = ((n % 256) < int'(m_active));
            if ((n % 256) == 255) m_active = m_pending;
            m_strobe = 1'b0;
            m_next   = 1'b0;
            if (IwEnable) begin
                if ((en_run % DIV) == 0) begin
                    k = en_run / DIV;
                    if ((k % 2) == 0) begin
                        m_word   = bus.IbAudioSamples;
                        byte_sel = m_word[7:0];
                        m_next   = 1'b1;
                    end else begin
                        byte_sel = m_word[15:8];
                    end
                    v  = int'($signed(byte_sel));
                    sc = 1 << m_vol;
                    v  = (v >= 0) ? v / sc : -((-v + sc - 1) / sc);
                    m_sample  = v[7:0];
                    m_pending = 8'(v + 128);
                    m_strobe  = 1'b1;
                end
                en_run++;
            end else begin
                en_run    = 0;
                m_pending = 8'h80;
            end
            n++;
        end
    end

    logic chk_on = 1'b0;

    always @(negedge IwClk) begin
        if (chk_on) begin
            check_val("next",   32'(bus.OwNextAudioSamples), 32'(m_next));
            check_val("strobe", 32'(OwSampleStrobe),         32'(m_strobe));
            check_val("sample", {24'd0, ObSample},           {24'd0, m_sample});
            check_val("pwm",    32'(OwPwm),                  32'(m_pwm));
        end
    end

    int highs, pulses, strobes;
    logic [7:0] exp_vol;

    task automatic count_window(input int cycles);
        highs = 0; pulses = 0; strobes = 0;
        repeat (cycles) begin
            @(negedge IwClk);
            highs   += int'(OwPwm);
            pulses  += int'(bus.OwNextAudioSamples);
            strobes += int'(OwSampleStrobe);
        end
    endtask

    initial begin
        IwRst_n = 1'b0;
        IwEnable = 1'b0;
        IbVolume = 2'd0;
        bus.IbAudioSamples = 16'h7F80;
        repeat (3) @(posedge IwClk);
        #1;
        check_val("rst_pwm",    32'(OwPwm), 32'd0);
        check_val("rst_next",   32'(bus.OwNextAudioSamples), 32'd0);
        check_val("rst_strobe", 32'(OwSampleStrobe), 32'd0);
        check_val("rst_sample", {24'd0, ObSample}, 32'd0);
        @(negedge IwClk);
        IwRst_n = 1'b1;
        chk_on  = 1'b1;

        count_window(1024);
        check_val("idle_pulses", pulses, 0);
        check_val("idle_highs",  highs, 512);
        check_val("idle_sample", {24'd0, ObSample}, 32'd0);

        IwEnable = 1'b1;
        @(negedge IwClk);
        check_val("en_pulse", 32'(bus.OwNextAudioSamples), 32'd1);
        check_val("en_lo",    {24'd0, ObSample}, 32'h80);
        repeat (DIV) @(negedge IwClk);
        check_val("hi_sample",  {24'd0, ObSample}, 32'h7F);
        check_val("hi_strobe",  32'(OwSampleStrobe), 32'd1);
        check_val("hi_nopulse", 32'(bus.OwNextAudioSamples), 32'd0);
        repeat (DIV) @(negedge IwClk);
        check_val("second_pulse", 32'(bus.OwNextAudioSamples), 32'd1);

        bus.IbAudioSamples = 16'h7F7F;
        repeat (3 * DIV + 512) @(negedge IwClk);
        count_window(256);
        check_val("duty_max", highs, 255);
        bus.IbAudioSamples = 16'h8080;
        repeat (3 * DIV + 512) @(negedge IwClk);
        count_window(256);
        check_val("duty_min", highs, 0);

        IwEnable = 1'b0;
        @(negedge IwClk);
        bus.IbAudioSamples = 16'h5AA5;
        IwEnable = 1'b1;
        @(negedge IwClk);
        check_val("drop_lo_pulse", 32'(bus.OwNextAudioSamples), 32'd1);
        repeat (DIV / 2) @(negedge IwClk);
        IwEnable = 1'b0;
        count_window(244);
        count_window(256);
        check_val("drop_no_hi", strobes, 0);
        check_val("drop_half",  highs, 128);
        check_val("drop_keep",  {24'd0, ObSample}, 32'hA5);
        bus.IbAudioSamples = 16'h1234;
        IwEnable = 1'b1;
        @(negedge IwClk);
        check_val("reen_pulse", 32'(bus.OwNextAudioSamples), 32'd1);
        check_val("reen_lo",    {24'd0, ObSample}, 32'h34);

        IwEnable = 1'b0;
        @(negedge IwClk);
        bus.IbAudioSamples = 16'h0040;
        IbVolume = 2'd2;
        IwEnable = 1'b1;
        @(negedge IwClk);
`ifdef AUDIO_VOLUME_EN
        exp_vol = 8'h10;
`else
        exp_vol = 8'h40;
`endif
        check_val("vol_sample", {24'd0, ObSample}, {24'd0, exp_vol});

        repeat (20000) begin
            @(negedge IwClk);
            if ($urandom_range(0, 799) == 0) IwEnable = ~IwEnable;
            if ($urandom_range(0, 39) == 0) bus.IbAudioSamples = 16'($urandom);
            if ($urandom_range(0, 499) == 0) IbVolume = 2'($urandom_range(0, 3));
        end

        IwEnable = 1'b0;
        repeat (600) @(negedge IwClk);
        for (int i = 0; i < 300 && !OwPwm; i++) @(negedge IwClk);
        check_val("pre_rst_pwm", 32'(OwPwm), 32'd1);
        #2;
        chk_on  = 1'b0;
        IwRst_n = 1'b0;
        #1;
        check_val("arst_pwm",    32'(OwPwm), 32'd0);
        check_val("arst_next",   32'(bus.OwNextAudioSamples), 32'd0);
        check_val("arst_strobe", 32'(OwSampleStrobe), 32'd0);
        check_val("arst_sample", {24'd0, ObSample}, 32'd0);
        @(negedge IwClk);
        IwRst_n = 1'b1;
        chk_on  = 1'b1;
        IbVolume = 2'd0;
        IwEnable = 1'b1;
        repeat (1500) begin
            @(negedge IwClk);
            if ($urandom_range(0, 19) == 0) bus.IbAudioSamples = 16'($urandom);
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
